// File: rtl/wb_stage_pkg.sv
// Shared encodings and types for the writeback stage.
package wb_stage_pkg;

  localparam int XLEN = 32;

  // Writeback source select
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  // Load size/sign encodings (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_WAIT_LD = 1'b1
  } wb_state_e;

  // Control half of the MEM/WB register
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [4:0] rd;
    logic [1:0] wb_sel;
    logic [2:0] funct3;
  } wb_ctl_t;

endpackage

// File: rtl/wb_stage_load_extract.sv
// Picks the addressed byte/half out of a word-aligned read and extends it.
module load_extract
  import wb_stage_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] rdata,
  input  logic [1:0]   addr_lo,
  input  logic [2:0]   funct3,
  output logic [W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then sign/zero extension; unknown sizes pass the full word
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data = {{(W-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{(W-16){half_sel[15]}}, half_sel};
      F3_LBU:  data = {{(W-8){1'b0}}, byte_sel};
      F3_LHU:  data = {{(W-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register plus writeback: load wait, regfile write, instret.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wb_sel,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_pc4,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_rvalid,
  output logic             wb_en,
  output logic [XLEN-1:0]  wb_data,
  output logic [4:0]       rd_index,
  output logic             wb_stall,
  output logic [CNT_W-1:0] instret
);

  wb_state_e       state_q, state_d;
  wb_ctl_t         ctl_q;
  logic [XLEN-1:0] alu_q, pc4_q;
  logic [XLEN-1:0] ld_data;
  logic            retire;

  load_extract #(.W(XLEN)) u_ld (
    .rdata   (dmem_rdata),
    .addr_lo (alu_q[1:0]),
    .funct3  (ctl_q.funct3),
    .data    (ld_data)
  );

  // Pipeline register, state and retire counter; reset drops any pending load
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ctl_q   <= '0;
      alu_q   <= '0;
      pc4_q   <= '0;
      instret <= '0;
    end else begin
      state_q <= state_d;
      if (!wb_stall) begin
        ctl_q <= mem_valid ? wb_ctl_t'{valid: 1'b1, reg_write: mem_reg_write, rd: mem_rd,
                                       wb_sel: mem_wb_sel, funct3: mem_funct3}
                           : '0;
        alu_q <= mem_alu_result;
        pc4_q <= mem_pc4;
      end
      if (retire) instret <= instret + 1'b1;
    end
  end

  // Completion, stall, next state and write-port muxing
  always_comb begin
    state_d  = state_q;
    wb_stall = 1'b0;
    retire   = 1'b0;
    case (state_q)
      ST_RUN:     retire = ctl_q.valid;
      ST_WAIT_LD: begin
        wb_stall = !dmem_rvalid;
        retire   = dmem_rvalid;
      end
      default:    retire = 1'b0;
    endcase
    // A load only enters WAIT_LD when it is actually captured
    if (!wb_stall)
      state_d = (mem_valid && mem_wb_sel == WB_SEL_LOAD) ? ST_WAIT_LD : ST_RUN;

    wb_en    = retire & ctl_q.reg_write & (|ctl_q.rd);
    rd_index = ctl_q.rd;
    if (state_q == ST_WAIT_LD)       wb_data = ld_data;
    else if (ctl_q.wb_sel == WB_SEL_PC4) wb_data = pc4_q;
    else                             wb_data = alu_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage with hand-computed expectations.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result, mem_pc4;
  logic [2:0]  mem_funct3;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [4:0]  rd_index;
  logic        wb_stall;
  logic [63:0] instret;

  int n_cmp = 0;
  int n_bad = 0;

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result), .mem_pc4(mem_pc4),
    .mem_funct3(mem_funct3), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .wb_en(wb_en), .wb_data(wb_data), .rd_index(rd_index),
    .wb_stall(wb_stall), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [2:0] f3);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_rd         = rd;
    mem_wb_sel     = sel;
    mem_alu_result = alu;
    mem_pc4        = pc4;
    mem_funct3     = f3;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 3'b000);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; dmem_rdata = '0; dmem_rvalid = 1'b0;
    bubble();
    step(); step();
    rst = 1'b0;
    chk("rst_en",    64'(wb_en),    64'd0);
    chk("rst_data",  64'(wb_data),  64'd0);
    chk("rst_rd",    64'(rd_index), 64'd0);
    chk("rst_stall", 64'(wb_stall), 64'd0);
    chk("rst_cnt",   instret,       64'd0);

    // ALU writeback
    drive(1'b1, 1'b1, 5'd5, 2'b00, 32'h1234, 32'h0, 3'b000);
    step();
    chk("alu_en",    64'(wb_en),    64'd1);
    chk("alu_rd",    64'(rd_index), 64'd5);
    chk("alu_data",  64'(wb_data),  64'h1234);
    chk("alu_stall", 64'(wb_stall), 64'd0);

    // x0 write suppressed but still retires
    drive(1'b1, 1'b1, 5'd0, 2'b00, 32'hFFFF, 32'h0, 3'b000);
    step();
    chk("alu_cnt",   instret,       64'd1);
    chk("x0_en",     64'(wb_en),    64'd0);
    bubble();
    step();
    chk("x0_cnt",    instret,       64'd2);
    chk("bub_en",    64'(wb_en),    64'd0);
    step();
    chk("bub_cnt",   instret,       64'd2);

    // LB at a=2 with two wait cycles; next ALU op held on the inputs
    drive(1'b1, 1'b1, 5'd7, 2'b01, 32'h0000_1002, 32'h0, 3'b000);
    step();
    drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h55, 32'h0, 3'b000);
    chk("lb_stall1", 64'(wb_stall), 64'd1);
    chk("lb_en1",    64'(wb_en),    64'd0);
    step();
    chk("lb_stall2", 64'(wb_stall), 64'd1);
    chk("lb_rd",     64'(rd_index), 64'd7);
    step();
    chk("lb_stall3", 64'(wb_stall), 64'd1);
    dmem_rdata = 32'h0080_0000; dmem_rvalid = 1'b1;
    #1;
    chk("lb_stall0", 64'(wb_stall), 64'd0);
    chk("lb_en",     64'(wb_en),    64'd1);
    chk("lb_data",   64'(wb_data),  64'hFFFF_FF80);
    chk("lb_cnt_hold", instret,     64'd2);
    step();
    dmem_rvalid = 1'b0;
    bubble();
    #1;
    chk("nxt_rd",    64'(rd_index), 64'd9);
    chk("nxt_data",  64'(wb_data),  64'h55);
    chk("nxt_en",    64'(wb_en),    64'd1);
    chk("lb_cnt",    instret,       64'd3);
    step();
    chk("nxt_cnt",   instret,       64'd4);

    // LHU a=2 then LH a=0 back to back, zero-wait memory
    drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0000_2002, 32'h0, 3'b101);
    step();
    drive(1'b1, 1'b1, 5'd4, 2'b01, 32'h0000_2000, 32'h0, 3'b001);
    dmem_rdata = 32'h8001_7FFF; dmem_rvalid = 1'b1;
    #1;
    chk("lhu_stall", 64'(wb_stall), 64'd0);
    chk("lhu_data",  64'(wb_data),  64'h0000_8001);
    chk("lhu_rd",    64'(rd_index), 64'd3);
    step();
    bubble();
    #1;
    chk("lh_data",   64'(wb_data),  64'h0000_7FFF);
    chk("lh_en",     64'(wb_en),    64'd1);
    chk("lh_rd",     64'(rd_index), 64'd4);
    step();
    dmem_rvalid = 1'b0;
    chk("lh_cnt",    instret,       64'd6);

    // JAL writes PC+4; rvalid in RUN is ignored
    drive(1'b1, 1'b1, 5'd1, 2'b10, 32'h0000_DEAD, 32'h0000_0108, 3'b000);
    step();
    bubble();
    dmem_rdata = 32'hAAAA_AAAA; dmem_rvalid = 1'b1;
    #1;
    chk("jal_data",  64'(wb_data),  64'h108);
    chk("jal_en",    64'(wb_en),    64'd1);
    chk("jal_stall", 64'(wb_stall), 64'd0);
    step();
    chk("spur_en",   64'(wb_en),    64'd0);
    chk("spur_cnt",  instret,       64'd7);
    dmem_rvalid = 1'b0;

    // Reserved select behaves as ALU
    drive(1'b1, 1'b1, 5'd2, 2'b11, 32'h0000_0077, 32'h0000_0999, 3'b000);
    step();
    bubble();
    chk("rsv_data",  64'(wb_data),  64'h77);
    step();

    // Reset in the middle of a pending load
    drive(1'b1, 1'b1, 5'd6, 2'b01, 32'h0000_3000, 32'h0, 3'b010);
    step();
    bubble();
    chk("rl_stall",  64'(wb_stall), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rl_stall0", 64'(wb_stall), 64'd0);
    chk("rl_en",     64'(wb_en),    64'd0);
    chk("rl_cnt",    instret,       64'd0);
    dmem_rdata = 32'h1234_5678; dmem_rvalid = 1'b1;
    #1;
    chk("rl_late_en", 64'(wb_en),   64'd0);
    step();
    dmem_rvalid = 1'b0;
    chk("rl_late_cnt", instret,     64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
